// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and one-cycle bubble insertion.
// Optional stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic [4:0]  IF_ID_RegisterRd,
  input  logic [31:0] IF_ID_ReadData1,
  input  logic [31:0] IF_ID_ReadData2,
  input  logic [31:0] IF_ID_Imm,
  input  logic        IF_ID_RegWrite,
  input  logic        IF_ID_MemRead,
  input  logic        IF_ID_MemWrite,
  input  logic        IF_ID_MemtoReg,
  input  logic        IF_ID_ALUSrc,
  input  logic        IF_ID_RegDst,
  input  logic [1:0]  IF_ID_ALUOp,
  input  logic        Flush,
  output logic [4:0]  ID_EX_RegisterRs,
  output logic [4:0]  ID_EX_RegisterRt,
  output logic [4:0]  ID_EX_RegisterRd,
  output logic [31:0] ID_EX_ReadData1,
  output logic [31:0] ID_EX_ReadData2,
  output logic [31:0] ID_EX_Imm,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_MemtoReg,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_RegDst,
  output logic [1:0]  ID_EX_ALUOp,
  output logic        PCWrite,
  output logic        IF_ID_Write,
`ifdef ID_EX_STALL_CNT_EN
  output logic [15:0] StallCount,
`endif
  output logic        Stall
);

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_dst;
    logic [1:0]  alu_op;
  } stage_t;

  typedef enum logic {RUN, BUBBLE} state_t;

  stage_t id_stage;
  stage_t ex_stage;
  state_t state;
  logic   hazard;

  assign id_stage = '{
    rs:         IF_ID_RegisterRs,
    rt:         IF_ID_RegisterRt,
    rd:         IF_ID_RegisterRd,
    read_data1: IF_ID_ReadData1,
    read_data2: IF_ID_ReadData2,
    imm:        IF_ID_Imm,
    reg_write:  IF_ID_RegWrite,
    mem_read:   IF_ID_MemRead,
    mem_write:  IF_ID_MemWrite,
    mem_to_reg: IF_ID_MemtoReg,
    alu_src:    IF_ID_ALUSrc,
    reg_dst:    IF_ID_RegDst,
    alu_op:     IF_ID_ALUOp
  };

  // Load in EX whose destination is a source of the instruction in ID.
  assign hazard = ex_stage.mem_read && (ex_stage.rt != 5'd0) &&
                  ((ex_stage.rt == IF_ID_RegisterRs) || (ex_stage.rt == IF_ID_RegisterRt));

  assign Stall       = hazard && !Flush;
  assign PCWrite     = !Stall;
  assign IF_ID_Write = !Stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_stage <= '0;
      state    <= RUN;
    end else if (Flush) begin
      ex_stage <= '0;
      state    <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            ex_stage <= '0;
            state    <= BUBBLE;
          end else begin
            ex_stage <= id_stage;
          end
        end
        // The bubble carries MemRead=0, so no hazard can exist here; capture and resume.
        BUBBLE: begin
          ex_stage <= id_stage;
          state    <= RUN;
        end
        default: begin
          ex_stage <= '0;
          state    <= RUN;
        end
      endcase
    end
  end

  assign ID_EX_RegisterRs = ex_stage.rs;
  assign ID_EX_RegisterRt = ex_stage.rt;
  assign ID_EX_RegisterRd = ex_stage.rd;
  assign ID_EX_ReadData1  = ex_stage.read_data1;
  assign ID_EX_ReadData2  = ex_stage.read_data2;
  assign ID_EX_Imm        = ex_stage.imm;
  assign ID_EX_RegWrite   = ex_stage.reg_write;
  assign ID_EX_MemRead    = ex_stage.mem_read;
  assign ID_EX_MemWrite   = ex_stage.mem_write;
  assign ID_EX_MemtoReg   = ex_stage.mem_to_reg;
  assign ID_EX_ALUSrc     = ex_stage.alu_src;
  assign ID_EX_RegDst     = ex_stage.reg_dst;
  assign ID_EX_ALUOp      = ex_stage.alu_op;

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_count;

  // Counts load-use bubbles only; Stall is already low when Flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (Stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign StallCount = stall_count;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, load-use bubbles, flush, async reset.
// Define ID_EX_STALL_CNT_EN to also exercise the stall counter.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rd1, rd2, imm;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
  logic [1:0]  alu_op;
  logic        flush;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [1:0]  ex_alu_op;
  logic        pc_write, if_id_write, stall;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_RegisterRd(rd),
    .IF_ID_ReadData1(rd1), .IF_ID_ReadData2(rd2), .IF_ID_Imm(imm),
    .IF_ID_RegWrite(reg_write), .IF_ID_MemRead(mem_read), .IF_ID_MemWrite(mem_write),
    .IF_ID_MemtoReg(mem_to_reg), .IF_ID_ALUSrc(alu_src), .IF_ID_RegDst(reg_dst),
    .IF_ID_ALUOp(alu_op), .Flush(flush),
    .ID_EX_RegisterRs(ex_rs), .ID_EX_RegisterRt(ex_rt), .ID_EX_RegisterRd(ex_rd),
    .ID_EX_ReadData1(ex_rd1), .ID_EX_ReadData2(ex_rd2), .ID_EX_Imm(ex_imm),
    .ID_EX_RegWrite(ex_reg_write), .ID_EX_MemRead(ex_mem_read), .ID_EX_MemWrite(ex_mem_write),
    .ID_EX_MemtoReg(ex_mem_to_reg), .ID_EX_ALUSrc(ex_alu_src), .ID_EX_RegDst(ex_reg_dst),
    .ID_EX_ALUOp(ex_alu_op),
    .PCWrite(pc_write), .IF_ID_Write(if_id_write),
`ifdef ID_EX_STALL_CNT_EN
    .StallCount(stall_count),
`endif
    .Stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] s, t, d, input logic rw, mr, m2r, src, dst,
                           input logic [1:0] op, input logic [31:0] d1, d2, im);
    rs = s; rt = t; rd = d;
    reg_write = rw; mem_read = mr; mem_write = 1'b0; mem_to_reg = m2r;
    alu_src = src; reg_dst = dst; alu_op = op;
    rd1 = d1; rd2 = d2; imm = im;
    #1;
  endtask

  // lw $t, 4($4)
  task automatic lw(input logic [4:0] t);
    set_instr(5'd4, t, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h44, 32'h0, 32'd4);
  endtask

  // R-type: d = s op t
  task automatic rtype(input logic [4:0] s, t, d, input logic [31:0] d1);
    set_instr(s, t, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, d1, 32'h5A, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    set_instr('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);

    // During reset: outputs 0, no stall, even with live inputs across an edge
    rtype(5'd2, 5'd3, 5'd1, 32'h11);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_pcwrite", {31'd0, pc_write}, 32'd1);
    check("rst_ifid_write", {31'd0, if_id_write}, 32'd1);
    tick();
    check("rst_hold_rs", {27'd0, ex_rs}, 32'd0);
    check("rst_hold_regwrite", {31'd0, ex_reg_write}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_pcwrite", {31'd0, pc_write}, 32'd1);

    // Independent add $1,$2,$3 then sub $4,$5,$6
    tick();
    check("add_rs", {27'd0, ex_rs}, 32'd2);
    check("add_rt", {27'd0, ex_rt}, 32'd3);
    check("add_rd", {27'd0, ex_rd}, 32'd1);
    check("add_rd1", ex_rd1, 32'h11);
    check("add_rd2", ex_rd2, 32'h5A);
    check("add_aluop", {30'd0, ex_alu_op}, 32'd2);
    check("add_regdst", {31'd0, ex_reg_dst}, 32'd1);
    set_instr(5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h22, 32'h66, 32'h0);
    check("sub_nostall", {31'd0, stall}, 32'd0);
    tick();
    check("sub_rs", {27'd0, ex_rs}, 32'd5);
    check("sub_rd", {27'd0, ex_rd}, 32'd4);
    check("sub_rd1", ex_rd1, 32'h22);
    check("sub_stall", {31'd0, stall}, 32'd0);

    // lw $8 then add $9,$8,$10
    lw(5'd8);
    tick();
    check("lw_memread", {31'd0, ex_mem_read}, 32'd1);
    check("lw_memtoreg", {31'd0, ex_mem_to_reg}, 32'd1);
    check("lw_alusrc", {31'd0, ex_alu_src}, 32'd1);
    check("lw_rt", {27'd0, ex_rt}, 32'd8);
    check("lw_imm", ex_imm, 32'd4);
    rtype(5'd8, 5'd10, 5'd9, 32'h33);
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_pcwrite", {31'd0, pc_write}, 32'd0);
    check("lu_ifid_write", {31'd0, if_id_write}, 32'd0);
    tick();
    check("bub_rs", {27'd0, ex_rs}, 32'd0);
    check("bub_rd", {27'd0, ex_rd}, 32'd0);
    check("bub_regwrite", {31'd0, ex_reg_write}, 32'd0);
    check("bub_memread", {31'd0, ex_mem_read}, 32'd0);
    check("bub_rd1", ex_rd1, 32'd0);
    check("bub_rd2", ex_rd2, 32'd0);
    check("bub_imm", ex_imm, 32'd0);
    check("bub_aluop", {30'd0, ex_alu_op}, 32'd0);
    check("bub_stall", {31'd0, stall}, 32'd0);
    check("bub_pcwrite", {31'd0, pc_write}, 32'd1);
    tick();
    check("lu_add_rs", {27'd0, ex_rs}, 32'd8);
    check("lu_add_rd", {27'd0, ex_rd}, 32'd9);
    check("lu_add_rd1", ex_rd1, 32'h33);
    check("lu_add_stall", {31'd0, stall}, 32'd0);

    // Rs and Rt both match: exactly one stall cycle
    lw(5'd8);
    tick();
    rtype(5'd8, 5'd8, 5'd9, 32'h34);
    check("both_stall", {31'd0, stall}, 32'd1);
    tick();
    check("both_bub_regwrite", {31'd0, ex_reg_write}, 32'd0);
    check("both_bub_stall", {31'd0, stall}, 32'd0);
    tick();
    check("both_add_rt", {27'd0, ex_rt}, 32'd8);
    check("both_add_regwrite", {31'd0, ex_reg_write}, 32'd1);

    // lw $0 then add $9,$0,$0: no stall, no bubble
    lw(5'd0);
    tick();
    check("lw0_memread", {31'd0, ex_mem_read}, 32'd1);
    rtype(5'd0, 5'd0, 5'd9, 32'h35);
    check("lw0_stall", {31'd0, stall}, 32'd0);
    tick();
    check("lw0_add_rd", {27'd0, ex_rd}, 32'd9);
    check("lw0_add_rd1", ex_rd1, 32'h35);

    // Hazard and Flush together: flush wins
    lw(5'd8);
    tick();
    rtype(5'd8, 5'd10, 5'd9, 32'h36);
    flush = 1'b1;
    #1;
    check("fl_stall", {31'd0, stall}, 32'd0);
    check("fl_pcwrite", {31'd0, pc_write}, 32'd1);
    check("fl_ifid_write", {31'd0, if_id_write}, 32'd1);
    tick();
    check("fl_bub_rs", {27'd0, ex_rs}, 32'd0);
    check("fl_bub_regwrite", {31'd0, ex_reg_write}, 32'd0);
    check("fl_bub_rd1", ex_rd1, 32'd0);
    flush = 1'b0;
    #1;
    check("fl_after_stall", {31'd0, stall}, 32'd0);
    tick();
    check("fl_run_capture_rs", {27'd0, ex_rs}, 32'd8);
    check("fl_run_capture_rd1", ex_rd1, 32'h36);

    // Flush of a plain instruction also bubbles
    rtype(5'd2, 5'd3, 5'd1, 32'h37);
    flush = 1'b1;
    tick();
    check("fl_plain_rd", {27'd0, ex_rd}, 32'd0);
    flush = 1'b0;

    // Back-to-back loads: lw $8; lw $9,0($8); add $10,$9,$1
    lw(5'd8);
    tick();
    set_instr(5'd8, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h48, 32'h0, 32'd0);
    check("b2b_stall1", {31'd0, stall}, 32'd1);
    tick();
    check("b2b_bub1_stall", {31'd0, stall}, 32'd0);
    tick();
    check("b2b_lw2_memread", {31'd0, ex_mem_read}, 32'd1);
    check("b2b_lw2_rt", {27'd0, ex_rt}, 32'd9);
    rtype(5'd9, 5'd1, 5'd10, 32'h38);
    check("b2b_stall2", {31'd0, stall}, 32'd1);
    tick();
    check("b2b_bub2_stall", {31'd0, stall}, 32'd0);
    check("b2b_bub2_memread", {31'd0, ex_mem_read}, 32'd0);
    tick();
    check("b2b_add_rd", {27'd0, ex_rd}, 32'd10);

    // Async reset between edges while a hazard is pending
    lw(5'd8);
    tick();
    rtype(5'd8, 5'd10, 5'd9, 32'h39);
    check("ar_pre_stall", {31'd0, stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_memread", {31'd0, ex_mem_read}, 32'd0);
    check("ar_rt", {27'd0, ex_rt}, 32'd0);
    check("ar_imm", ex_imm, 32'd0);
    check("ar_stall", {31'd0, stall}, 32'd0);
    check("ar_pcwrite", {31'd0, pc_write}, 32'd1);
    tick();
    #2 rst_n = 1'b1;

    // Reset during BUBBLE: bubble abandoned, next edge captures Rd=17
    tick();
    lw(5'd8);
    tick();
    rtype(5'd8, 5'd10, 5'd9, 32'h3A);
    check("rb_stall", {31'd0, stall}, 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rb_rs", {27'd0, ex_rs}, 32'd0);
    check("rb_stall_in_rst", {31'd0, stall}, 32'd0);
    rtype(5'd8, 5'd10, 5'd17, 32'h3B);
    #1 rst_n = 1'b1;
    tick();
    check("rb_capture_rd", {27'd0, ex_rd}, 32'd17);
    check("rb_capture_rs", {27'd0, ex_rs}, 32'd8);
    check("rb_capture_rd1", ex_rd1, 32'h3B);
    check("rb_capture_stall", {31'd0, stall}, 32'd0);

`ifdef ID_EX_STALL_CNT_EN
    // Counter: reset, three hazards, one flushed hazard, then saturation
    #2 rst_n = 1'b0;
    #1;
    check("cnt_rst", {16'd0, stall_count}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lw(5'd8);
      tick();
      rtype(5'd8, 5'd10, 5'd9, 32'h40);
      tick();
      tick();
    end
    check("cnt_three", {16'd0, stall_count}, 32'd3);
    lw(5'd8);
    tick();
    rtype(5'd8, 5'd10, 5'd9, 32'h41);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cnt_flush_not_counted", {16'd0, stall_count}, 32'd3);
    force dut.stall_count = 16'hFFFF;
    #1;
    release dut.stall_count;
    lw(5'd8);
    tick();
    rtype(5'd8, 5'd10, 5'd9, 32'h42);
    tick();
    check("cnt_saturate", {16'd0, stall_count}, 32'h0000FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd  in  5 each  decoded register numbers.
- IF_ID_ReadData1, IF_ID_ReadData2, IF_ID_Imm  in  32 each  register-file reads, sign-extended immediate.
- IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_MemtoReg, IF_ID_ALUSrc, IF_ID_RegDst  in  1 each  decoded controls.
- IF_ID_ALUOp  in  2  decoded ALU op.
- Flush  in  1  taken branch/jump, discard the ID instruction.
- ID_EX_*  out  same widths  registered copies of every IF_ID_* input above (feeding the forwarding unit and EX).
- PCWrite, IF_ID_Write  out  1 each  0 = hold PC / IF_ID register.
- Stall  out  1  load-use hazard detected this cycle.
- StallCount  out  16  load-use bubble count (only with REQ-016 macro).

Function
REQ-002 The block SHALL implement a single clock with asynchronous active-low reset (clk, rst_n).
REQ-003 The block SHALL capture every IF_ID_* input into the matching ID_EX_* output on each rising clk edge with no hazard and no Flush; latency is 1 cycle.
REQ-004 Hazard SHALL be combinational: ID_EX_MemRead=1, ID_EX_RegisterRt!=0, and ID_EX_RegisterRt equal to IF_ID_RegisterRs or IF_ID_RegisterRt.
REQ-005 Stall SHALL equal hazard AND NOT Flush; PCWrite and IF_ID_Write SHALL equal NOT Stall.
REQ-006 A bubble SHALL load all ID_EX_* outputs with 0: controls, ALUOp, register numbers and data.
REQ-007 The FSM SHALL have states RUN and BUBBLE; RUN -> BUBBLE on a clock edge with Stall=1, inserting a bubble.
REQ-008 In BUBBLE, the block SHALL capture normally, since the bubble has MemRead=0, and SHALL return to RUN; any new hazard is evaluated afresh from the captured values.
REQ-009 Flush=1 at an edge SHALL load a bubble, force the state to RUN, and take priority over hazard; PCWrite and IF_ID_Write stay 1.
REQ-010 A load with Rt=0 SHALL never stall; a match on both Rs and Rt SHALL produce a single one-cycle stall.
REQ-011 Back-to-back loads with a dependency SHALL stall once per dependent consumer; stall is never longer than 1 cycle per hazard.

Reset
REQ-012 On rst_n=0 all ID_EX_* outputs and StallCount SHALL go to 0 and the state to RUN immediately, without waiting for clk.
REQ-013 During reset and in the first cycle after it, Stall SHALL be 0 and PCWrite and IF_ID_Write SHALL be 1.
REQ-014 Reset asserted mid-stall SHALL abandon the bubble; the first post-reset edge captures the IF_ID_* inputs normally.
REQ-015 No output SHALL be X after reset is released with defined inputs.

Configuration
REQ-016 With ID_EX_STALL_CNT_EN defined, StallCount SHALL increment by 1 on each edge with Stall=1 and saturate at 16'hFFFF; Flush bubbles are not counted.
REQ-017 With ID_EX_STALL_CNT_EN undefined, the StallCount port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-018 Scenario: lw $8 then add $9,$8,$10 -> Stall=1 for one cycle, PCWrite=0, next ID_EX_* all 0, add captured one cycle later, ID_EX_RegisterRs=8.
REQ-019 Scenario: lw $0 then add $9,$0,$0 -> Stall stays 0 and there is no bubble.
REQ-020 Scenario: hazard and Flush=1 in the same cycle -> Stall=0, PCWrite=1, bubble loaded, state RUN.
REQ-021 Scenario: rst_n pulled low between edges during BUBBLE -> outputs 0 at once; after release, the next edge captures IF_ID_RegisterRd=5'd17 unchanged.
REQ-022 Scenario (macro on): 3 hazards -> StallCount=3; preload 16'hFFFF then one more hazard -> StallCount remains 16'hFFFF.
REQ-023 Scenario: independent add $1,$2,$3 then sub $4,$5,$6 -> captured on consecutive edges, Stall=0 throughout.
